instr_sequencer: RTL and testbench

//  Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RISC core datapath.

---
 rtl/instr_sequencer_pkg.sv | 46 ++++
 rtl/instr_sequencer_if.sv | 38 +++
 rtl/instr_sequencer_mem_wait_timer.sv | 26 ++
 rtl/instr_sequencer.sv | 156 +++++++++++++++
 tb/tb_instr_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package instr_sequencer_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned FAULT_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALTED, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_CALL, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  localparam logic [OP_W-1:0] OP_LOAD  = 6'd3;
  localparam logic [OP_W-1:0] OP_STORE = 6'd4;
  localparam logic [OP_W-1:0] OP_CALL  = 6'd10;
  localparam logic [OP_W-1:0] OP_HALT  = 6'd63;

  // One bit per opcode value: ALU = 0..2, BRANCH = 5..9, 11, 12
  localparam logic [63:0] ALU_SET    = 64'h0000_0000_0000_0007;
  localparam logic [63:0] BRANCH_SET = 64'h0000_0000_0000_1BE0;

  localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_REG    = 2'd2;

  localparam logic [FAULT_W-1:0] FC_NONE    = 2'd0;
  localparam logic [FAULT_W-1:0] FC_ILLEGAL = 2'd1;
  localparam logic [FAULT_W-1:0] FC_IMEM    = 2'd2;
  localparam logic [FAULT_W-1:0] FC_DMEM    = 2'd3;

  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    op_class_t cls;
    if (ALU_SET[op])         cls = CLS_ALU;
    else if (BRANCH_SET[op]) cls = CLS_BRANCH;
    else if (op == OP_LOAD)  cls = CLS_LOAD;
    else if (op == OP_STORE) cls = CLS_STORE;
    else if (op == OP_CALL)  cls = CLS_CALL;
    else if (op == OP_HALT)  cls = CLS_HALT;
    else                     cls = CLS_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Core/datapath <-> sequencer control bus.
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  import instr_sequencer_pkg::*;

  logic                start;
  logic                stop_req;
  logic [OP_W-1:0]     op_code;
  logic                branch_taken;
  logic                imem_ack;
  logic                dmem_ack;
  logic                imem_req;
  logic                ir_load;
  logic                dmem_req;
  logic                dmem_we;
  logic                rf_we;
  logic                pc_load;
  logic [PC_SRC_W-1:0] pc_src;
  logic                busy;
  logic                halted;
  logic                fault;
  logic [FAULT_W-1:0]  fault_code;
  logic [CNT_W-1:0]    retired;

  modport master (
    output start, stop_req, op_code, branch_taken, imem_ack, dmem_ack,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_load, pc_src,
           busy, halted, fault, fault_code, retired
  );

  modport slave (
    input  start, stop_req, op_code, branch_taken, imem_ack, dmem_ack,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_load, pc_src,
           busy, halted, fault, fault_code, retired
  );

endinterface

// File: rtl/instr_sequencer_mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request; expired marks the last allowed cycle.
module instr_sequencer_mem_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXECUTE/MEM/WB sequencer: gates datapath strobes, handles memory handshakes,
// counts retirements and owns halt/fault.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic             clk,
  input logic             reset,
  instr_sequencer_if.slave bus
);

  state_t              state;
  state_t              next_state;
  op_class_t           op_cls;
  logic                stop_q;
  logic                retire;
  logic                waiting;
  logic                timer_clear;
  logic                wait_expired;
  logic [PC_SRC_W-1:0] pc_src_c;
  logic [FAULT_W-1:0]  fault_code_d;

  logic                imem_req_q;
  logic                dmem_req_q;
  logic                dmem_we_q;
  logic                rf_we_q;
  logic                busy_q;
  logic                halted_q;
  logic                fault_q;
  logic [FAULT_W-1:0]  fault_code_q;
  logic [CNT_W-1:0]    retired_q;

  // Wait counter restarts on every entry to FETCH/MEM and runs while the request is unanswered
  assign waiting     = ((state == S_FETCH) && (next_state == S_FETCH)) ||
                       ((state == S_MEM)   && (next_state == S_MEM));
  assign timer_clear = !waiting;

  instr_sequencer_mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (waiting),
    .expired (wait_expired)
  );

  // Next state, retirement and the strobes that depend on same-cycle acks or branch_taken
  always_comb begin
    next_state   = state;
    retire       = 1'b0;
    pc_src_c     = PC_SRC_SEQ;
    fault_code_d = fault_code_q;
    case (state)
      S_IDLE: begin
        if (bus.start) next_state = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          next_state = S_DECODE;
        end else if (wait_expired) begin
          next_state   = S_FAULT;
          fault_code_d = FC_IMEM;
        end
      end
      S_DECODE: begin
        case (op_class(bus.op_code))
          CLS_HALT:    next_state = S_HALTED;
          CLS_ILLEGAL: begin
            next_state   = S_FAULT;
            fault_code_d = FC_ILLEGAL;
          end
          default:     next_state = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (op_cls)
          CLS_ALU, CLS_CALL:    next_state = S_WB;
          CLS_LOAD, CLS_STORE:  next_state = S_MEM;
          default: begin
            retire   = 1'b1;
            pc_src_c = bus.branch_taken ? PC_SRC_BRANCH : PC_SRC_SEQ;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (op_cls == CLS_LOAD) next_state = S_WB;
          else                    retire     = 1'b1;
        end else if (wait_expired) begin
          next_state   = S_FAULT;
          fault_code_d = FC_DMEM;
        end
      end
      S_WB: begin
        retire   = 1'b1;
        pc_src_c = (op_cls == CLS_CALL) ? PC_SRC_REG : PC_SRC_SEQ;
      end
      default: next_state = state;
    endcase
    if (retire) next_state = stop_q ? S_IDLE : S_FETCH;
  end

  // State, opcode class, stop latch, counter and next-state-decoded registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op_cls       <= CLS_ALU;
      stop_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      retired_q    <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_cls <= op_class(bus.op_code);
      // Entering IDLE consumes the stop request; stop_req seen idle without start is ignored
      if ((next_state == S_IDLE) && (state != S_IDLE)) begin
        stop_q <= 1'b0;
      end else if (bus.stop_req && ((state != S_IDLE) || bus.start)) begin
        stop_q <= 1'b1;
      end
      imem_req_q   <= (next_state == S_FETCH);
      dmem_req_q   <= (next_state == S_MEM);
      dmem_we_q    <= (next_state == S_MEM) && (op_cls == CLS_STORE);
      rf_we_q      <= (next_state == S_WB);
      busy_q       <= !((next_state == S_IDLE) || (next_state == S_HALTED) ||
                        (next_state == S_FAULT));
      halted_q     <= (next_state == S_HALTED);
      fault_q      <= (next_state == S_FAULT);
      fault_code_q <= fault_code_d;
      retired_q    <= retired_q + CNT_W'(retire);
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.ir_load    = (state == S_FETCH) && bus.imem_ack;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.pc_load    = retire;
  assign bus.pc_src     = pc_src_c;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: per-instruction expectations queued at issue, checked at retirement.
module tb_instr_sequencer;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam int unsigned TB_CNT_W   = 32;

  typedef struct {
    int         cycles;
    logic       rf;
    logic [1:0] pc_src;
    int         dreq;
    logic [31:0] retired;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   model_ret;
  exp_t sb[$];

  instr_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

  instr_sequencer #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 CALL, 5 HALT, 6 illegal
  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd2:                          return 0;
      6'd3:                                      return 1;
      6'd4:                                      return 2;
      6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd11, 6'd12: return 3;
      6'd10:                                     return 4;
      6'd63:                                     return 5;
      default:                                   return 6;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop_req = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_ret = 0;
  endtask

  task automatic pulse_start(input logic with_stop);
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop_req = with_stop;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Runs one retiring instruction from its FETCH cycle (cycle 1); ilat/dlat = ack wait cycles
  task automatic run_instr(input logic [5:0] op, input logic taken, input int ilat,
                           input int dlat, input int stop_cyc);
    exp_t e;
    exp_t got_e;
    int   k;
    int   cyc;
    int   iw;
    int   dw;
    int   n_ir;
    int   n_dreq;
    int   n_rf;
    logic bad_we;
    logic done;
    k = cls_of(op);
    cyc = 0; iw = 0; dw = 0; n_ir = 0; n_dreq = 0; n_rf = 0;
    bad_we = 1'b0; done = 1'b0;
    e.cycles = ((k == 3) ? 3 : (k == 1) ? 5 : 4) + ilat + (((k == 1) || (k == 2)) ? dlat : 0);
    e.rf = (k == 0) || (k == 1) || (k == 4);
    e.pc_src = (k == 4) ? 2'd2 : ((k == 3) && taken) ? 2'd1 : 2'd0;
    e.dreq = ((k == 1) || (k == 2)) ? dlat + 1 : 0;
    model_ret++;
    e.retired = 32'(model_ret);
    sb.push_back(e);
    bus.op_code = op;
    bus.branch_taken = taken;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == stop_cyc) bus.stop_req = 1'b1;
      bus.imem_ack = bus.imem_req && (iw >= ilat);
      bus.dmem_ack = bus.dmem_req && (dw >= dlat);
      if (bus.imem_req) iw++;
      if (bus.dmem_req) dw++;
      #1;
      if (bus.ir_load) n_ir++;
      if (bus.dmem_req) begin
        n_dreq++;
        if (bus.dmem_we !== (k == 2)) bad_we = 1'b1;
      end
      if (bus.pc_load) begin
        got_e = sb.pop_front();
        check_eq("latency", 64'(cyc), 64'(got_e.cycles));
        check_eq("rf_we_at_retire", 64'(bus.rf_we), 64'(got_e.rf));
        check_eq("pc_src", 64'(bus.pc_src), 64'(got_e.pc_src));
        check_eq("dmem_req_cycles", 64'(n_dreq), 64'(got_e.dreq));
        check_eq("ir_load_count", 64'(n_ir), 64'd1);
        check_eq("dmem_we_bad", 64'(bad_we), 64'd0);
        check_eq("rf_we_early", 64'(n_rf), 64'd0);
        done = 1'b1;
      end else if (bus.rf_we) begin
        n_rf++;
      end
    end
    check_eq("retire_seen", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    check_eq("retired", 64'(bus.retired), 64'(e.retired));
  endtask

  // Runs a non-retiring instruction until halted/fault; negative latency means never ack
  task automatic run_to_end(input logic [5:0] op, input int ilat, input int dlat,
                            output int n_ireq, output int n_dreq, output int n_rf,
                            output logic ended);
    int iw;
    int dw;
    iw = 0; dw = 0; n_ireq = 0; n_dreq = 0; n_rf = 0; ended = 1'b0;
    bus.op_code = op;
    bus.branch_taken = 1'b0;
    for (int c = 0; c < 64 && !ended; c++) begin
      @(negedge clk);
      bus.imem_ack = bus.imem_req && (ilat >= 0) && (iw >= ilat);
      bus.dmem_ack = bus.dmem_req && (dlat >= 0) && (dw >= dlat);
      if (bus.imem_req) iw++;
      if (bus.dmem_req) dw++;
      #1;
      if (bus.fault || bus.halted) begin
        ended = 1'b1;
      end else begin
        if (bus.imem_req) n_ireq++;
        if (bus.dmem_req) n_dreq++;
        if (bus.rf_we || bus.pc_load) n_rf++;
      end
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    int   n_ireq;
    int   n_dreq;
    int   n_rf;
    int   n;
    logic ended;
    errors = 0;
    checks = 0;
    model_ret = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop_req = 1'b0;
    bus.op_code = '0;
    bus.branch_taken = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    do_reset();
    check_eq("rst_imem_req", 64'(bus.imem_req), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_retired", 64'(bus.retired), 64'd0);
    check_eq("rst_fault", 64'(bus.fault), 64'd0);
    check_eq("rst_halted", 64'(bus.halted), 64'd0);

    // Back-to-back retiring instructions with assorted waits
    pulse_start(1'b0);
    run_instr(6'd0, 1'b0, 0, 0, 0);
    run_instr(6'd3, 1'b0, 0, 3, 0);
    run_instr(6'd5, 1'b1, 0, 0, 0);
    run_instr(6'd10, 1'b0, 0, 0, 0);
    run_instr(6'd4, 1'b0, 1, 2, 0);
    run_instr(6'd11, 1'b0, 2, 0, 0);
    // Fetch ack on the final allowed cycle, with stop requested mid-instruction
    run_instr(6'd1, 1'b0, int'(TB_TIMEOUT) - 1, 0, 2);
    check_eq("stop_busy", 64'(bus.busy), 64'd0);
    check_eq("stop_imem_req", 64'(bus.imem_req), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("stop_stays_idle", 64'(bus.busy), 64'd0);
    bus.stop_req = 1'b0;

    // start together with stop: exactly one instruction
    pulse_start(1'b1);
    run_instr(6'd2, 1'b0, 0, 0, 0);
    check_eq("start_stop_idle", 64'(bus.busy), 64'd0);
    bus.stop_req = 1'b0;

    pulse_start(1'b0);
    run_instr(6'd3, 1'b0, 0, int'(TB_TIMEOUT) - 1, 0);
    run_instr(6'd12, 1'b1, 0, 0, 0);

    // Reset in the middle of a data access
    bus.op_code = 6'd3;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      bus.imem_ack = bus.imem_req;
      bus.dmem_ack = 1'b0;
      #1;
      if (bus.dmem_req) n++;
    end
    check_eq("mid_mem_dmem_req", 64'(bus.dmem_req), 64'd1);
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_dmem_req", 64'(bus.dmem_req), 64'd0);
    check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_mid_retired", 64'(bus.retired), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_ret = 0;

    // Instruction fetch timeout, terminal and deaf to start
    pulse_start(1'b0);
    run_to_end(6'd0, -1, 0, n_ireq, n_dreq, n_rf, ended);
    check_eq("imem_to_ended", 64'(ended), 64'd1);
    check_eq("imem_to_req_cycles", 64'(n_ireq), 64'(TB_TIMEOUT));
    check_eq("imem_to_code", 64'(bus.fault_code), 64'd2);
    check_eq("imem_to_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    check_eq("fault_held", 64'(bus.fault), 64'd1);
    check_eq("fault_imem_req", 64'(bus.imem_req), 64'd0);
    do_reset();
    check_eq("fault_cleared", 64'(bus.fault), 64'd0);

    // Data access timeout
    pulse_start(1'b0);
    run_to_end(6'd3, 0, -1, n_ireq, n_dreq, n_rf, ended);
    check_eq("dmem_to_ended", 64'(ended), 64'd1);
    check_eq("dmem_to_req_cycles", 64'(n_dreq), 64'(TB_TIMEOUT));
    check_eq("dmem_to_code", 64'(bus.fault_code), 64'd3);
    do_reset();

    // Illegal opcode
    pulse_start(1'b0);
    run_to_end(6'd20, 0, 0, n_ireq, n_dreq, n_rf, ended);
    check_eq("ill_fault", 64'(bus.fault), 64'd1);
    check_eq("ill_code", 64'(bus.fault_code), 64'd1);
    check_eq("ill_no_dmem", 64'(n_dreq), 64'd0);
    check_eq("ill_no_strobe", 64'(n_rf), 64'd0);
    do_reset();

    // HALT after one retirement
    pulse_start(1'b0);
    run_instr(6'd0, 1'b0, 0, 0, 0);
    run_to_end(6'd63, 0, 0, n_ireq, n_dreq, n_rf, ended);
    check_eq("halt_halted", 64'(bus.halted), 64'd1);
    check_eq("halt_busy", 64'(bus.busy), 64'd0);
    check_eq("halt_fault", 64'(bus.fault), 64'd0);
    check_eq("halt_retired", 64'(bus.retired), 64'(model_ret));
    check_eq("halt_no_strobe", 64'(n_rf), 64'd0);

    check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
